// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop sync, per-channel debounce, press strobes.
// Ports: clk, rst_n, btn_raw[3:0] -> btn_level[3:0], btn_pulse[3:0], any_pulse.
// Optional: BTN_AUTOREPEAT_EN adds hold-to-repeat strobes on channel 0 (hit).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic       any_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_rep
    $error("REPEAT_CYCLES must be >= 2");
  end

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    stable;
  logic [CW-1:0] cnt [4];
  logic [3:0]    accept;
  logic [3:0]    rep_fire;

  // accept: mismatch has persisted long enough, stable flips this edge
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;

  // level is high now and stays high across this edge
  always_comb begin
    rep_fire    = '0;
    rep_fire[0] = stable[0] && !accept[0] && (rep_cnt == REP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (!stable[0] || accept[0] || rep_fire[0]) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  assign rep_fire = '0;
`endif

  // strobe lines up with the cycle btn_level first reads 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_pulse <= '0;
    end else begin
      btn_pulse <= (accept & sync2) | rep_fire;
    end
  end

  assign btn_level = stable;
  assign any_pulse = |btn_pulse;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized cycles required to accept a level change; legal range >= 2.
REQ-002 Parameter REPEAT_CYCLES, default 12500000: auto-repeat period, used only under BTN_AUTOREPEAT_EN; legal range >= 2.
REQ-003 clk  input  1  single system clock, all state rising-edge triggered.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_raw  input  4  unsynchronized push buttons: bit0 hit, bit1 stand, bit2 double, bit3 start; active-high.
REQ-006 btn_level  output  4  debounced button level, one bit per channel.
REQ-007 btn_pulse  output  4  one-cycle press strobe per channel, feeding the game core's btn_* inputs.
REQ-008 any_pulse  output  1  OR of btn_pulse.

Function
REQ-009 Each channel SHALL pass btn_raw through a two-flop synchronizer; no logic SHALL sample btn_raw directly.
REQ-010 Each channel SHALL hold a stable register and a mismatch counter of width clog2(DEBOUNCE_CYCLES).
REQ-011 When the synchronized value equals stable, the counter SHALL clear to 0 on the next edge.
REQ-012 When the two differ and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment.
REQ-013 When the two differ and the counter equals DEBOUNCE_CYCLES-1, stable SHALL take the synchronized value and the counter SHALL clear.
REQ-014 Latency: btn_level SHALL change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples a new, thereafter held, btn_raw value.
REQ-015 Any raw excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave btn_level and btn_pulse unchanged and restart the count.
REQ-016 The counter SHALL never wrap; it is bounded by REQ-013.
REQ-017 btn_level SHALL equal the stable register.
REQ-018 btn_pulse[i] SHALL be high for exactly one cycle, the cycle in which btn_level[i] first reads 1 after reading 0; release SHALL NOT pulse.
REQ-019 Channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses, with no priority or masking here.
REQ-020 any_pulse SHALL be combinational from the btn_pulse registers, same cycle.

Reset
REQ-021 Asserting rst_n low SHALL immediately clear the synchronizers, stable registers, counters, previous-level registers and repeat counters to 0.
REQ-022 During reset, btn_level, btn_pulse and any_pulse SHALL be 0.
REQ-023 A button held through reset release SHALL be treated as a new press: full debounce latency, then one pulse.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL follow from it.

Configuration
REQ-025 Macro BTN_AUTOREPEAT_EN defined: channel 0 (hit) only SHALL emit an additional btn_pulse[0] after each REPEAT_CYCLES consecutive cycles that btn_level[0] stays high following the press pulse, repeating until release.
REQ-026 With the macro defined, the repeat counter SHALL clear on release, on reset, and on each repeat pulse.
REQ-027 Macro undefined: no repeat counter SHALL be built, and every channel SHALL emit exactly one pulse per accepted press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-028 btn_raw[0] 0->1 held -> btn_level[0] rises 6 edges later; btn_pulse[0] high exactly 1 cycle; any_pulse matches it.
REQ-029 btn_raw[1] high for 3 cycles, then low -> btn_level[1] and btn_pulse[1] stay 0 throughout.
REQ-030 btn_raw[3:0]=4'b1111 in the same cycle, held -> btn_pulse=4'b1111 for one cycle, then 4'b0000.
REQ-031 btn_raw[2] held, rst_n pulsed low mid-debounce, then released -> outputs 0 during reset; one pulse 6 edges after release.
REQ-032 BTN_AUTOREPEAT_EN defined, btn_raw[0] held 40 cycles after acceptance -> pulses at acceptance and every 10 cycles after; release stops them. Macro undefined -> exactly one pulse.
